mipi_tx_raw10_packer: RTL
=========================

# mipi_tx_raw10_packer

Packs 10-bit Bayer pixels, four per input beat, into the MIPI CSI-2 RAW10 byte stream and emits it as 32-bit little-endian words. It sits at the head of the CSI-2 transmit/loopback path, upstream of header/ECC insertion. It is the exact inverse of `mipi_rx_raw10_depacker`. It throttles its source with a ready signal, because every 4 input beats become 5 output words. At line end it flushes and pads the tail, and reports the line byte count for the packet header.

## Interface
Parameters:
- PAD_BYTE, 8'h00, fill byte for the final partial word of a line
- BC_W, 16, width of byte_count_o; the count saturates at all-ones

Ports:
- clk_i  in  1  pixel/byte clock
- reset_i  in  1  asynchronous, active-low reset
- line_valid_i  in  1  high for the duration of a line; a falling level ends the line
- data_valid_i  in  1  data_i holds a pixel group
- data_i  in  40  pixel k in bits [10k+9:10k], k = 0..3
- data_ready_o  out  1  a group is accepted on an edge where data_valid_i, data_ready_o and line_valid_i are all high
- output_valid_o  out  1  output_o is valid this cycle; there is no backpressure
- output_o  out  32  packed bytes; byte 0 is in [7:0]
- line_end_o  out  1  one-cycle pulse marking the end of a line
- byte_count_o  out  BC_W  payload bytes emitted in the last line, including pad; updated with line_end_o

## Operation
- **Group encoding.** Each group becomes 5 bytes, in this order:
  - P0[9:2], P1[9:2], P2[9:2], P3[9:2]
  - {P3[1:0], P2[1:0], P1[1:0], P0[1:0]}
- **Byte buffer.** A 64-bit buffer holds `cnt` bytes, with `cnt` in 0..8 (4-bit register). The oldest byte is at [7:0].
- **Each cycle:**
  - `emit` = (cnt ≥ 4), or (state FLUSH and cnt > 0).
  - If `emit`, the low 4 bytes leave the buffer. In FLUSH with cnt < 4, the missing bytes are PAD_BYTE.
  - An accepted group appends 5 bytes after the bytes remaining post-emit.
- **Ready rule.** `data_ready_o` = state ACTIVE && (cnt − (cnt ≥ 4 ? 4 : 0)) ≤ 3. It is combinational from registers only.
- **States:**
  - IDLE: line_valid_i high → ACTIVE. Clear the running count.
  - ACTIVE: line_valid_i low → FLUSH. Input is ignored while line_valid_i is low.
  - FLUSH: `data_ready_o` is low. On the cycle the last emit happens (or immediately if cnt = 0):
    - pulse line_end_o,
    - latch the running count into byte_count_o,
    - → IDLE.
- **Running byte count.** Adds 4 per emitted word and saturates.
- **line_valid_i re-rising during FLUSH** is ignored until IDLE is reached. The new line starts from IDLE one cycle later.
- **Reset** (async assert, sync release): cnt = 0, state IDLE. All outputs are 0, including byte_count_o.

## Timing
- **Latency.** A group accepted at edge N gives its first word on output_o/output_valid_o after edge N+1. Outputs are registered.
- **Steady stream.** Ready is high for 4 of every 5 cycles. cnt sequence after acceptance is 5, 6, 7, 8, 4, 5, …, which yields 5 words per 4 groups.
- **Flush length.** Worst case is 2 emit cycles (cnt = 8).
- **line_end_o timing:**
  - coincides with the final word when the buffer was non-empty at line end;
  - otherwise it is a standalone pulse, one cycle after the line_valid_i fall is sampled, with output_valid_o low.
- **byte_count_o** changes only on the line_end_o cycle. It is stable otherwise.
- **Reset asserted mid-line** drops any buffered bytes. No line_end_o is issued.

## Structure
- `mipi_tx_pkg` holds:
  - RAW10_PIX_W = 10
  - RAW10_GROUP_BYTES = 5
  - the pure function raw10_encode(40b) → 40b byte arrangement
  - the state enum {IDLE, ACTIVE, FLUSH}
- No sub-module. Encoder, buffer and FSM live in one file, roughly 150–250 lines.

## Test plan
- **Single group.** Reset, then one group P0=0x3FF, P1=0x000, P2=0x155, P3=0x2AA, then line_valid_i falls.
  - Word 32'hAA5500FF, then 32'h00000093 with line_end_o in the same cycle.
  - byte_count_o = 8.
- **Steady stream.** 8 back-to-back groups.
  - data_ready_o follows the pattern H,H,H,H,L repeating.
  - Exactly 10 words. Byte stream equals the concatenated 5-byte encodings.
  - byte_count_o = 40 with no pad.
- **Empty line.** line_valid_i high for 5 cycles with no data_valid_i.
  - Standalone line_end_o, no output_valid_o, byte_count_o = 0.
- **PAD_BYTE = 8'hFF with 3 groups** (15 bytes).
  - Last word has byte 3 = 8'hFF.
  - byte_count_o = 16.
- **Reset mid-line.** reset_i low with cnt = 7.
  - All outputs go to 0 immediately.
  - The next line starts clean; the first word equals that line's first group's bytes 0–3.
- **Loopback.** Random pixels through this block, then `mipi_rx_raw10_depacker`.
  - Recovered 40-bit groups equal the input, in order, across 3 lines.

Source files
------------

// File: rtl/mipi_tx_pkg.sv
// Shared constants, FSM states and the RAW10 group encoder for the CSI-2 TX packer.
package mipi_tx_pkg;

  localparam int RAW10_PIX_W       = 10;
  localparam int RAW10_GROUP_BYTES = 5;

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} tx_state_e;

  // Four 10-bit pixels -> five bytes: four MSB bytes, then the packed 2-bit LSBs.
  function automatic logic [39:0] raw10_encode(input logic [39:0] pix);
    logic [39:0] enc;
    enc = '0;
    for (int k = 0; k < 4; k++) begin
      enc[8*k +: 8]    = pix[RAW10_PIX_W*k + 2 +: 8];
      enc[32 + 2*k +: 2] = pix[RAW10_PIX_W*k +: 2];
    end
    return enc;
  endfunction

endpackage

// File: rtl/mipi_tx_raw10_packer.sv
// RAW10 packer: 4-pixel groups into a little-endian 32-bit byte stream, with
// line-end flush/pad and a saturating per-line byte count.
module mipi_tx_raw10_packer
  import mipi_tx_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = 8'h00,
  parameter int         BC_W     = 16
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            line_valid_i,
  input  logic            data_valid_i,
  input  logic [39:0]     data_i,
  output logic            data_ready_o,
  output logic            output_valid_o,
  output logic [31:0]     output_o,
  output logic            line_end_o,
  output logic [BC_W-1:0] byte_count_o
);

  localparam int NUM_LANES = 4;

  tx_state_e        state, state_nxt;
  logic [3:0]       cnt, cnt_nxt, rem, avail;
  logic [63:0]      byte_buf, buf_nxt, shifted;
  logic [39:0]      enc;
  logic [NUM_LANES-1:0][7:0] word;
  logic             emit, accept, done;
  logic [BC_W-1:0]  run_cnt, run_nxt;
  logic [BC_W:0]    run_sum;

  assign enc   = raw10_encode(data_i);
  assign emit  = (cnt >= 4'd4) || ((state == FLUSH) && (cnt != 4'd0));
  assign avail = (cnt >= 4'd4) ? cnt - 4'd4 : cnt;
  // A short flush word drains everything, so nothing remains after it.
  assign rem   = (cnt >= 4'd4) ? cnt - 4'd4 : (emit ? 4'd0 : cnt);
  assign done  = (state == FLUSH) && (cnt <= 4'd4);

  assign data_ready_o = (state == ACTIVE) && (avail <= 4'd3);
  assign accept       = data_valid_i && line_valid_i && data_ready_o;

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      assign word[i] = (4'(i) < cnt) ? byte_buf[8*i +: 8] : PAD_BYTE;
    end
  endgenerate

  // Bytes above cnt are always zero, so new groups can be OR-ed in place.
  always_comb begin
    shifted = emit ? {32'h0, byte_buf[63:32]} : byte_buf;
    buf_nxt = shifted;
    cnt_nxt = rem;
    if (accept) begin
      buf_nxt = shifted | ({24'h0, enc} << {rem[2:0], 3'b000});
      cnt_nxt = rem + 4'(RAW10_GROUP_BYTES);
    end
  end

  always_comb begin
    run_sum = {1'b0, run_cnt} + (BC_W+1)'(4);
    run_nxt = run_cnt;
    if (emit) run_nxt = run_sum[BC_W] ? '1 : run_sum[BC_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (line_valid_i)  state_nxt = ACTIVE;
      ACTIVE:  if (!line_valid_i) state_nxt = FLUSH;
      FLUSH:   if (done)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state          <= IDLE;
      cnt            <= '0;
      byte_buf       <= '0;
      run_cnt        <= '0;
      output_valid_o <= 1'b0;
      output_o       <= '0;
      line_end_o     <= 1'b0;
      byte_count_o   <= '0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      byte_buf       <= buf_nxt;
      run_cnt        <= (state == IDLE && line_valid_i) ? '0 : run_nxt;
      output_valid_o <= emit;
      line_end_o     <= done;
      if (emit) output_o     <= word;
      if (done) byte_count_o <= run_nxt;
    end
  end

endmodule
